// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the VGA raster sink:
//   - default 640x480@60 timing constants (25 MHz pixel clock)
//   - FSM state enum for the stream sink (SEEK / RUN)
//   - colour-bar lookup used by the optional test pattern (VGA_TEST_PATTERN_EN)
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int CW_DEF       = 11;

    // SEEK: draining the stream until a start-of-packet lands on pixel (0,0).
    // RUN : locked to the stream, one pixel consumed per active clock.
    typedef enum logic {
        SEEK = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Eight vertical bars, left to right.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;  // white
            3'd1:    c = 24'hFFFF00;  // yellow
            3'd2:    c = 24'h00FFFF;  // cyan
            3'd3:    c = 24'h00FF00;  // green
            3'd4:    c = 24'hFF00FF;  // magenta
            3'd5:    c = 24'hFF0000;  // red
            3'd6:    c = 24'h0000FF;  // blue
            default: c = 24'h000000;  // black
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// vga_raster_counter
// Horizontal/vertical raster position counters plus the decoded timing
// strobes for one VGA mode.
//   clk       in   pixel clock
//   i_clr     in   synchronous clear to position (0,0), active-high
//   o_h_cnt   out  current pixel within line
//   o_v_cnt   out  current line within frame
//   o_active  out  position is inside the visible area
//   o_hs_int  out  position is inside the hsync pulse (polarity-free)
//   o_vs_int  out  line is inside the vsync pulse (polarity-free)
module vga_raster_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int CW       = 11
)(
    input  logic          clk,
    input  logic          i_clr,
    output logic [CW-1:0] o_h_cnt,
    output logic [CW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_hs_int,
    output logic          o_vs_int
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_h_cnt  = r_h_cnt;
    assign o_v_cnt  = r_v_cnt;
    assign o_active = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign o_hs_int = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    // vsync spans whole lines, so it only looks at the line counter
    assign o_vs_int = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);

endmodule

// File: rtl/vga_timing_sink.sv
// vga_timing_sink
// VGA raster generator that sinks a 24-bit RGB ready/valid pixel stream
// (with start-of-packet) and drives sync, blank and colour to the DAC.
// Optional feature macro: VGA_TEST_PATTERN_EN (colour bars on test_mode=1).
//   clk          in   pixel clock (video PLL output)
//   rst          in   synchronous reset, active-high
//   pll_locked   in   PLL lock flag, asynchronous to clk
//   in_data      in   pixel {R,G,B}
//   in_sop       in   first pixel of frame
//   in_valid     in   pixel available
//   in_ready     out  pixel consumed this cycle when in_valid is high
//   vga_hs/vs    out  sync outputs, active level SYNC_POL
//   vga_blank_n  out  high during active video
//   vga_r/g/b    out  colour, zero whenever blanked
//   underflow    out  sticky stream error, cleared by rst or loss of lock
//   test_mode    in   colour-bar select (ignored unless VGA_TEST_PATTERN_EN)
module vga_timing_sink
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FRONT  = H_FRONT_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BACK   = H_BACK_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FRONT  = V_FRONT_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BACK   = V_BACK_DEF,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CW       = CW_DEF
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_locked,
    input  logic [23:0] in_data,
    input  logic        in_sop,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        underflow,
    input  logic        test_mode
);

    logic          r_lock_meta;
    logic          r_lock_s;
    logic          w_hold;
    logic [CW-1:0] w_h_cnt;
    logic [CW-1:0] w_v_cnt;
    logic          w_active;
    logic          w_hs_int;
    logic          w_vs_int;
    logic          w_origin;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_ready;
    logic          w_uf_set;
    logic [23:0]   w_pix;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank_n;
    logic [23:0]   r_rgb;
    logic          r_uf;

    // Two-flop synchronizer for the PLL lock flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Everything downstream sits in its reset state until the clock is trusted.
    assign w_hold = rst | ~r_lock_s;

    vga_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .CW       (CW)
    ) u_raster (
        .clk      (clk),
        .i_clr    (w_hold),
        .o_h_cnt  (w_h_cnt),
        .o_v_cnt  (w_v_cnt),
        .o_active (w_active),
        .o_hs_int (w_hs_int),
        .o_vs_int (w_vs_int)
    );

    assign w_origin = (w_h_cnt == '0) && (w_v_cnt == '0);

`ifndef VGA_TEST_PATTERN_EN
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;
`endif

    always_ff @(posedge clk) begin
        if (w_hold) r_state <= SEEK;
        else        r_state <= w_state_nxt;
    end

    // w_pix is the colour registered for this raster position; it is left at
    // black for every blanked or discarded cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_uf_set    = 1'b0;
        w_pix       = 24'h000000;
        if (!w_hold) begin
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode) begin
                // Bars replace the stream; keep draining so the source never
                // stalls, and resync from scratch when test mode ends.
                w_ready     = 1'b1;
                w_state_nxt = SEEK;
                if (w_active)
                    w_pix = bar_color(3'(w_h_cnt / CW'(H_ACTIVE / 8)));
            end else begin
`else
            begin
`endif
                case (r_state)
                    SEEK: begin
                        w_ready = 1'b1;
                        if (w_origin && in_valid && in_sop) begin
                            w_pix       = in_data;
                            w_state_nxt = RUN;
                        end
                    end
                    RUN: begin
                        w_ready = w_active;
                        if (w_active) begin
                            if (w_origin) begin
                                // Frame start must coincide with sop.
                                if (in_valid && in_sop) begin
                                    w_pix = in_data;
                                end else begin
                                    w_uf_set    = 1'b1;
                                    w_state_nxt = SEEK;
                                end
                            end else if (!in_valid) begin
                                w_uf_set = 1'b1;
                            end else if (in_sop) begin
                                // Stream restarted mid-frame: drop it and resync.
                                w_uf_set    = 1'b1;
                                w_state_nxt = SEEK;
                            end else begin
                                w_pix = in_data;
                            end
                        end
                    end
                    default: w_state_nxt = SEEK;
                endcase
            end
        end
    end

    // Outputs registered one clock after the counters; sync delayed alongside
    // blank so the three stay aligned at the connector.
    always_ff @(posedge clk) begin
        if (w_hold) begin
            r_hs      <= ~SYNC_POL;
            r_vs      <= ~SYNC_POL;
            r_blank_n <= 1'b0;
            r_rgb     <= 24'h000000;
            r_uf      <= 1'b0;
        end else begin
            r_hs      <= w_hs_int ? SYNC_POL : ~SYNC_POL;
            r_vs      <= w_vs_int ? SYNC_POL : ~SYNC_POL;
            r_blank_n <= w_active;
            r_rgb     <= w_pix;
            r_uf      <= r_uf | w_uf_set;
        end
    end

    assign in_ready    = w_ready;
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_r       = r_rgb[23:16];
    assign vga_g       = r_rgb[15:8];
    assign vga_b       = r_rgb[7:0];
    assign underflow   = r_uf;

endmodule

// File: tb/tb_vga_timing_sink.sv
// Testbench for vga_timing_sink, using a shrunken raster (24x10 clocks,
// 16x6 visible) so whole frames are cheap.
module tb_vga_timing_sink;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 10
    localparam int FR = HT * VT;             // 240 clocks per frame
    localparam int NPIX = HA * VA;           // 96 visible pixels

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_sop = 1'b0;
    logic        in_valid = 1'b0;
    logic        test_mode = 1'b0;
    logic        in_ready, vga_hs, vga_vs, vga_blank_n, underflow;
    logic [7:0]  vga_r, vga_g, vga_b;

    always #5 clk = ~clk;

    vga_timing_sink #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .CW(11)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .in_data(in_data), .in_sop(in_sop), .in_valid(in_valid),
        .in_ready(in_ready), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g),
        .vga_b(vga_b), .underflow(underflow), .test_mode(test_mode)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The raster is a free-running frame position; the stream is either
    // aligned (pixels shown) or not (black until sop lands on position 0).
    int          m_pos = 0;
    bit          m_al = 0, m_uf = 0, m_l1 = 0, m_l2 = 0;
    logic        exp_hs = 1'b1, exp_vs = 1'b1, exp_bl = 1'b0;
    logic [23:0] exp_rgb = '0;

    function automatic logic [23:0] bar(input int h);
        case (h / (HA / 8))
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic bit tm_on();
`ifdef VGA_TEST_PATTERN_EN
        return test_mode === 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_ready();
        int h, v;
        h = m_pos % HT;
        v = m_pos / HT;
        if (rst || !m_l2) return 1'b0;
        if (tm_on() || !m_al) return 1'b1;
        return (h < HA) && (v < VA);
    endfunction

    always @(posedge clk) begin : model
        int h, v;
        bit act, hold;
        hold = rst || !m_l2;
        if (hold) begin
            m_pos = 0; m_al = 0; m_uf = 0;
            exp_hs = 1'b1; exp_vs = 1'b1; exp_bl = 1'b0; exp_rgb = '0;
        end else begin
            h = m_pos % HT;
            v = m_pos / HT;
            act = (h < HA) && (v < VA);
            exp_bl  = act;
            exp_hs  = !(h >= HA + HF && h < HA + HF + HS);
            exp_vs  = !(v >= VA + VF && v < VA + VF + VS);
            exp_rgb = '0;
            if (tm_on()) begin
                if (act) exp_rgb = bar(h);
                m_al = 0;
            end else if (!m_al) begin
                if (m_pos == 0 && in_valid && in_sop) begin
                    exp_rgb = in_data;
                    m_al = 1;
                end
            end else if (act) begin
                if (m_pos == 0) begin
                    if (in_valid && in_sop) exp_rgb = in_data;
                    else begin m_uf = 1; m_al = 0; end
                end else if (!in_valid) m_uf = 1;
                else if (in_sop) begin m_uf = 1; m_al = 0; end
                else exp_rgb = in_data;
            end
            m_pos = (m_pos + 1) % FR;
        end
        m_l2 = rst ? 1'b0 : m_l1;
        m_l1 = rst ? 1'b0 : pll_locked;
    end

    // ---------------- compare process ----------------
    bit chk_on = 0;
    always @(negedge clk) begin
        #2;
        if (chk_on) begin
            chk("outputs", {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, underflow},
                {exp_hs, exp_vs, exp_bl, exp_rgb, m_uf});
            chk("in_ready", in_ready, exp_ready());
        end
    end

    // ---------------- stream source ----------------
    int          idx = 0;
    logic [23:0] cur = 24'h123456;
    bit          took = 0, src_en = 0, early = 0;
    int          drop_pct = 0, wh_left = 0;
    logic        rst_q = 1'b1, lock_q = 1'b0;

    task automatic cyc();
        @(negedge clk);
        rst = rst_q;
        pll_locked = lock_q;
        if (took) begin
            idx = (idx + 1) % NPIX;
            cur = $urandom;
        end
        in_data = cur;
        in_sop  = (idx == 0);
        if (!src_en) in_valid = 1'b0;
        else if (wh_left > 0) begin in_valid = 1'b0; wh_left--; end
        else if (idx == 0) in_valid = early || (m_pos == 0);
        else in_valid = ($urandom_range(99) >= drop_pct);
        #1;
        took = in_valid && in_ready;
        if (took) early = 0;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (m_pos != p && n < 2 * FR) begin cyc(); n++; end
        chk("wait_pos", m_pos, p);
    endtask

    task automatic inject_early();
        early = 1; idx = 0; cur = $urandom; took = 0;
    endtask

    initial begin
        int hs_lo, vs_lo, bl_hi, rdy_hi, t1, t2;
        logic prev_vs;

        // reset state
        repeat (3) cyc();
        chk_on = 1;
        chk("rst_hs", vga_hs, 1'b1);
        chk("rst_vs", vga_vs, 1'b1);
        chk("rst_blank_n", vga_blank_n, 1'b0);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_underflow", underflow, 1'b0);

        // lock, idle stream: timing counts over one frame window
        rst_q = 1'b0; lock_q = 1'b1;
        repeat (10) cyc();
        hs_lo = 0; vs_lo = 0; bl_hi = 0;
        for (int i = 0; i < FR; i++) begin
            cyc();
            hs_lo += !vga_hs; vs_lo += !vga_vs; bl_hi += vga_blank_n;
        end
        chk("hs_low_per_frame", hs_lo, HS * VT);
        chk("vs_low_per_frame", vs_lo, VS * HT);
        chk("blank_hi_per_frame", bl_hi, NPIX);
        t1 = -1; t2 = -1; prev_vs = vga_vs;
        for (int i = 0; i < 2 * FR; i++) begin
            cyc();
            if (prev_vs && !vga_vs) begin
                if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
            end
            prev_vs = vga_vs;
        end
        chk("frame_period", t2 - t1, FR);
        chk("idle_underflow", underflow, 1'b0);

        // clean stream
        src_en = 1;
        repeat (3 * FR) cyc();
        rdy_hi = 0;
        for (int i = 0; i < FR; i++) begin cyc(); rdy_hi += in_ready; end
        chk("run_ready_per_frame", rdy_hi, NPIX);
        chk("clean_underflow", underflow, 1'b0);

        // withhold valid for 5 active clocks on line 2
        wait_pos(2 * HT + 2);
        wh_left = 5;
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("withhold_rgb", {vga_r, vga_g, vga_b}, 24'h0);
            chk("withhold_blank_n", vga_blank_n, 1'b1);
        end
        chk("withhold_underflow", underflow, 1'b1);
        repeat (FR) cyc();
        chk("underflow_sticky", underflow, 1'b1);

        // drop lock on line 3
        wait_pos(3 * HT + 4);
        lock_q = 1'b0;
        repeat (4) cyc();
        chk("lockloss_blank_n", vga_blank_n, 1'b0);
        chk("lockloss_hs", vga_hs, 1'b1);
        chk("lockloss_rgb", {vga_r, vga_g, vga_b}, 24'h0);
        chk("lockloss_ready", in_ready, 1'b0);
        chk("lockloss_underflow", underflow, 1'b0);
        repeat (5) cyc();
        lock_q = 1'b1;
        repeat (3 * FR) cyc();
        chk("relock_underflow", underflow, 1'b0);

        // early sop mid-frame
        wait_pos(2 * HT + 4);
        inject_early();
        repeat (3) cyc();
        chk("early_sop_underflow", underflow, 1'b1);
        repeat (3 * FR) cyc();
        rdy_hi = 0;
        for (int i = 0; i < FR; i++) begin cyc(); rdy_hi += in_ready; end
        chk("resume_ready_per_frame", rdy_hi, NPIX);

        // test pattern
        test_mode = 1'b1;
        repeat (FR) cyc();
        wait_pos(2 * HT + 5);
        cyc();
`ifdef VGA_TEST_PATTERN_EN
        chk("bar_cyan", {vga_r, vga_g, vga_b}, 24'h00FFFF);
        chk("bar_ready", in_ready, 1'b1);
`endif
        repeat (FR) cyc();
        test_mode = 1'b0;

        // randomized stream with faults
        drop_pct = 3;
        for (int i = 0; i < 15 * FR; i++) begin
            if ($urandom_range(399) == 0) inject_early();
            if ($urandom_range(1999) == 0) test_mode = ~test_mode;
            rst_q  = ($urandom_range(2999) == 0);
            lock_q = ($urandom_range(2999) != 0) ? 1'b1 : 1'b0;
            cyc();
        end
        rst_q = 1'b0; lock_q = 1'b1;
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
